// File: rtl/kim_pip_pkg.sv
// Shared types and constants for the pipeline sequencing controller:
// FSM encoding, default sizing and the per-stage control bundle.
package kim_pip_pkg;

    localparam logic [1:0] ST_INIT     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    typedef enum logic [1:0] {
        INIT     = ST_INIT,
        RUN      = ST_RUN,
        MEM_WAIT = ST_MEM_WAIT
    } state_e;

    localparam int DEF_MAX_WAIT  = 16;
    localparam int DEF_CNT_WIDTH = 32;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_INIT = '{if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                         ex_mem_flush: 1'b1, mem_wb_flush: 1'b1,
                                         default: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{mem_wb_flush: 1'b1, default: 1'b0};
    localparam pipe_ctrl_t CTRL_FLOW   = '{pc_write: 1'b1, if_id_write: 1'b1,
                                           id_ex_write: 1'b1, ex_mem_write: 1'b1,
                                           default: 1'b0};

    // Normal-flow arbitration: branch redirect beats load-use stall beats jump.
    function automatic pipe_ctrl_t run_ctrl(input logic stall, input logic jump,
                                            input logic branch_taken);
        pipe_ctrl_t c;
        c = CTRL_FLOW;
        if (branch_taken) begin
            c.if_id_flush  = 1'b1;
            c.id_ex_flush  = 1'b1;
            c.ex_mem_flush = 1'b1;
        end else if (stall) begin
            c.pc_write    = 1'b0;
            c.if_id_write = 1'b0;
            c.id_ex_flush = 1'b1;
        end else if (jump) begin
            c.if_id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/kim_sat_counter.sv
// Up-counter with increment enable that sticks at all ones instead of wrapping.
module kim_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/kim_pipeline_ctrl.sv
// Pipeline sequencing controller: merges stall, redirects and data-memory
// waits into stage write/flush controls, with wait timeout and stall counter.
module kim_pipeline_ctrl
    import kim_pip_pkg::*;
#(
    parameter int MAX_WAIT  = DEF_MAX_WAIT,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 stall,
    input  logic                 jump,
    input  logic                 branch_taken,
    input  logic                 dmem_req,
    input  logic                 dmem_ack,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 id_ex_write,
    output logic                 ex_mem_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mem_wb_flush,
    output logic                 dmem_err,
    output logic                 dmem_err_sticky,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              sticky_q, sticky_d;
    pipe_ctrl_t        ctrl;
    logic              stall_inc;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = CTRL_INIT;
        dmem_err   = 1'b0;
        unique case (state_q)
            INIT: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
            RUN: begin
                if (dmem_req && !dmem_ack) begin
                    ctrl       = CTRL_FREEZE;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    ctrl = run_ctrl(stall, jump, branch_taken);
                end
            end
            MEM_WAIT: begin
                if (dmem_ack || (wait_cnt_q == WAIT_LAST)) begin
                    // A timeout releases exactly like an ack, just flagged as an error.
                    ctrl       = run_ctrl(stall, jump, branch_taken);
                    dmem_err   = !dmem_ack;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    ctrl       = CTRL_FREEZE;
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d    = INIT;
                wait_cnt_d = '0;
            end
        endcase
        sticky_d  = sticky_q | dmem_err;
        stall_inc = (state_q != INIT) && !ctrl.pc_write;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            wait_cnt_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            sticky_q   <= sticky_d;
        end
    end

    kim_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    assign pc_write        = ctrl.pc_write;
    assign if_id_write     = ctrl.if_id_write;
    assign id_ex_write     = ctrl.id_ex_write;
    assign ex_mem_write    = ctrl.ex_mem_write;
    assign if_id_flush     = ctrl.if_id_flush;
    assign id_ex_flush     = ctrl.id_ex_flush;
    assign ex_mem_flush    = ctrl.ex_mem_flush;
    assign mem_wb_flush    = ctrl.mem_wb_flush;
    assign dmem_err_sticky = sticky_q;

endmodule
